mac_accumulator: RTL and testbench

//  Sequential stage directly downstream of the 16x16 array multiplier: takes its 32-bit

---
 rtl/mac_acc_pkg.sv | 15 +
 rtl/mac_sat_adder.sv | 29 ++
 rtl/mac_accumulator.sv | 107 ++++++++++
 tb/tb_mac_accumulator.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_acc_pkg.sv
// Shared definitions for the MAC accumulator stage: FSM encodings and the
// default widths shared with the multiplier wrapper.
package mac_acc_pkg;

  localparam int unsigned MAC_PROD_W = 32;
  localparam int unsigned MAC_ACC_W  = 40;
  localparam int unsigned MAC_TERMS  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } mac_state_t;

endpackage

// File: rtl/mac_sat_adder.sv
// Accumulator adder: acc + zero-extended product, computed one bit wider so
// the carry out flags overflow. With MAC_ACC_SATURATE_EN defined the sum
// clamps to all ones on overflow; otherwise it wraps modulo 2^ACC_W.
module mac_sat_adder
  import mac_acc_pkg::*;
#(
  parameter int unsigned PROD_W = MAC_PROD_W,
  parameter int unsigned ACC_W  = MAC_ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] product,
  output logic [ACC_W-1:0]  sum_c,
  output logic              carry_c
);

  logic [ACC_W:0] wide_sum;

  // Widened unsigned add and overflow/clamp selection
  always_comb begin
    wide_sum = {1'b0, acc} + (ACC_W+1)'(product);
    carry_c  = wide_sum[ACC_W];
`ifdef MAC_ACC_SATURATE_EN
    sum_c    = carry_c ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
`else
    sum_c    = wide_sum[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/mac_accumulator.sv
// MAC accumulator: sums TERMS unsigned products taken under valid/ready into
// a wide accumulator and hands the result off under valid/ready.
// Optional build macro: MAC_ACC_SATURATE_EN (clamp on overflow instead of wrap).
module mac_accumulator
  import mac_acc_pkg::*;
#(
  parameter int unsigned PROD_W = MAC_PROD_W,
  parameter int unsigned ACC_W  = MAC_ACC_W,
  parameter int unsigned TERMS  = MAC_TERMS
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iStart,
  input  logic [PROD_W-1:0] iProduct,
  input  logic              iProdValid,
  output logic              oProdReady,
  output logic [ACC_W-1:0]  oResult,
  output logic              oResultValid,
  input  logic              iResultReady,
  output logic              oBusy,
  output logic              oOverflow
);

  localparam int unsigned     CNT_W     = $clog2(TERMS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TERMS - 1);

  mac_state_t       state;
  mac_state_t       state_next;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             ovf_next;
  logic [ACC_W-1:0] add_sum_c;
  logic             add_carry_c;

  mac_sat_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_adder (
    .acc     (acc),
    .product (iProduct),
    .sum_c   (add_sum_c),
    .carry_c (add_carry_c)
  );

  // Next-state, accumulator, counter and sticky-overflow logic.
  // oProdReady is high exactly in ACCUM, so iProdValid there is a transfer.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    count_next = count;
    ovf_next   = oOverflow;
    case (state)
      ST_IDLE: begin
        if (iStart) begin
          state_next = ST_ACCUM;
          acc_next   = '0;
          count_next = '0;
          ovf_next   = 1'b0;
        end
      end
      ST_ACCUM: begin
        if (iProdValid) begin
          acc_next   = add_sum_c;
          count_next = count + CNT_W'(1);
          ovf_next   = oOverflow | add_carry_c;
          if (count == LAST_CNT) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (iResultReady) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake/status outputs
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= ST_IDLE;
      acc          <= '0;
      count        <= '0;
      oOverflow    <= 1'b0;
      oProdReady   <= 1'b0;
      oResultValid <= 1'b0;
      oBusy        <= 1'b0;
    end else begin
      state        <= state_next;
      acc          <= acc_next;
      count        <= count_next;
      oOverflow    <= ovf_next;
      oProdReady   <= (state_next == ST_ACCUM);
      oResultValid <= (state_next == ST_DONE);
      oBusy        <= (state_next != ST_IDLE);
    end
  end

  assign oResult = acc;

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: scoreboard-checked random and directed runs on a
// TERMS=4 instance, directed overflow runs on an ACC_W=34/TERMS=8 instance.
module tb_mac_accumulator;

  localparam int unsigned PW = 32;
  localparam int unsigned AW = 40;
  localparam int unsigned AT = 4;
  localparam int unsigned BW = 34;
  localparam int unsigned BT = 8;

  typedef struct packed {
    logic [63:0] res;
    logic        ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;

  logic          a_start, a_pvalid, a_pready, a_rvalid, a_rready, a_busy, a_ovf;
  logic [PW-1:0] a_prod;
  logic [AW-1:0] a_result;

  logic          b_start, b_pvalid, b_pready, b_rvalid, b_rready, b_busy, b_ovf;
  logic [PW-1:0] b_prod;
  logic [BW-1:0] b_result;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  mac_accumulator #(.PROD_W(PW), .ACC_W(AW), .TERMS(AT)) dut_a (
    .Clock(clk), .Reset(rst), .iStart(a_start), .iProduct(a_prod),
    .iProdValid(a_pvalid), .oProdReady(a_pready), .oResult(a_result),
    .oResultValid(a_rvalid), .iResultReady(a_rready), .oBusy(a_busy),
    .oOverflow(a_ovf)
  );

  mac_accumulator #(.PROD_W(PW), .ACC_W(BW), .TERMS(BT)) dut_b (
    .Clock(clk), .Reset(rst), .iStart(b_start), .iProduct(b_prod),
    .iProdValid(b_pvalid), .oProdReady(b_pready), .oResult(b_result),
    .oResultValid(b_rvalid), .iResultReady(b_rready), .oBusy(b_busy),
    .oOverflow(b_ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: true unsigned sum of accepted products, then wrap or clamp
  function automatic exp_t model(input longint unsigned sum, input int unsigned w);
    longint unsigned maxv;
    exp_t e;
    maxv  = (64'd1 << w) - 64'd1;
    e.ovf = (sum > maxv);
`ifdef MAC_ACC_SATURATE_EN
    e.res = e.ovf ? maxv : sum;
`else
    e.res = sum & maxv;
`endif
    return e;
  endfunction

  // Scoreboard monitor: every result hand-off pops one expectation
  always @(negedge clk) begin
    if (!rst && a_rvalid && a_rready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got result 0x%0h, expected no result", a_result);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_result", 64'(a_result), mon_e.res);
        check("sb_ovf", 64'(a_ovf), 64'(mon_e.ovf));
      end
    end
  end

  // All tasks start and end just after a rising edge
  task automatic a_start_run(input bit offer, input logic [PW-1:0] p);
    a_start  = 1'b1;
    a_pvalid = offer;
    a_prod   = p;
    @(posedge clk); #1;
    a_start  = 1'b0;
    a_pvalid = 1'b0;
    check("start_busy", 64'(a_busy), 64'd1);
    check("start_pready", 64'(a_pready), 64'd1);
    check("start_acc_clear", 64'(a_result), 64'd0);
    check("start_ovf_clear", 64'(a_ovf), 64'd0);
  endtask

  task automatic a_send(input logic [PW-1:0] p, input int gap);
    bit got;
    got = 1'b0;
    repeat (gap) begin
      a_pvalid = 1'b0;
      a_prod   = PW'($urandom);
      @(posedge clk); #1;
    end
    a_prod   = p;
    a_pvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_pready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    a_pvalid = 1'b0;
  endtask

  task automatic a_finish(input exp_t e, input int hold, input bit offer, input bit start_pulse);
    check("done_latency", 64'(a_rvalid), 64'd1);
    check("done_pready", 64'(a_pready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      a_pvalid = offer;
      a_prod   = 32'h10;
      a_start  = start_pulse;
      @(posedge clk); #1;
      check("hold_valid", 64'(a_rvalid), 64'd1);
      check("hold_result", 64'(a_result), e.res);
      check("hold_pready", 64'(a_pready), 64'd0);
    end
    a_pvalid = 1'b0;
    a_start  = 1'b0;
    sb_q.push_back(e);
    a_rready = 1'b1;
    @(posedge clk); #1;
    a_rready = 1'b0;
    check("idle_valid", 64'(a_rvalid), 64'd0);
    check("idle_busy", 64'(a_busy), 64'd0);
    check("idle_result_kept", 64'(a_result), e.res);
    check("idle_ovf_kept", 64'(a_ovf), 64'(e.ovf));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint unsigned sum;
    logic [PW-1:0]   p;
    exp_t            e;

    rst = 1'b1;
    a_start = 0; a_pvalid = 0; a_prod = '0; a_rready = 0;
    b_start = 0; b_pvalid = 0; b_prod = '0; b_rready = 0;
    #2;
    check("rst_a_outputs", 64'({a_pready, a_rvalid, a_busy, a_ovf}), 64'd0);
    check("rst_a_result", 64'(a_result), 64'd0);
    check("rst_b_outputs", 64'({b_pready, b_rvalid, b_busy, b_ovf}), 64'd0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;

    // T1 back-to-back 1,2,3,4
    a_start_run(1'b0, '0);
    for (int i = 1; i <= 4; i++) a_send(PW'(i), 0);
    a_finish(model(64'd10, AW), 0, 1'b0, 1'b0);

    // T2 products with idle gaps
    a_start_run(1'b0, '0);
    a_send(32'd5, 1); a_send(32'd7, 1); a_send(32'd9, 1); a_send(32'd11, 1);
    a_finish(model(64'd32, AW), 1, 1'b0, 1'b0);

    // T4 held DONE with products offered
    a_start_run(1'b0, '0);
    for (int i = 1; i <= 4; i++) a_send(PW'(i * 256), 0);
    a_finish(model(64'hA00, AW), 5, 1'b1, 1'b0);

    // T5 reset mid-run, then a clean run
    a_start_run(1'b0, '0);
    a_send(32'd100, 0); a_send(32'd200, 0);
    #2;
    rst = 1'b1;
    #1;
    check("midrun_rst_outputs", 64'({a_pready, a_rvalid, a_busy, a_ovf}), 64'd0);
    check("midrun_rst_result", 64'(a_result), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    a_start_run(1'b0, '0);
    for (int i = 0; i < 4; i++) a_send(32'd3, 0);
    a_finish(model(64'd12, AW), 0, 1'b0, 1'b0);

    // T6 start with product in IDLE, start pulses in ACCUM and DONE
    a_start_run(1'b1, 32'h99);
    a_send(32'd2, 0);
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    check("accum_start_ignored", 64'({a_busy, a_pready}), 64'd3);
    a_send(32'd4, 0); a_send(32'd6, 0); a_send(32'd8, 0);
    a_finish(model(64'd20, AW), 3, 1'b0, 1'b1);

    // Random runs
    for (int r = 0; r < 12; r++) begin
      sum = 0;
      a_start_run(1'b0, '0);
      for (int k = 0; k < int'(AT); k++) begin
        p = PW'($urandom);
        sum += longint'(p);
        a_send(p, int'($urandom_range(0, 2)));
      end
      a_finish(model(sum, AW), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    end

    // T3 overflow on the narrow accumulator
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int i = 0; i < int'(BT); i++) begin
      check("b_pready", 64'(b_pready), 64'd1);
      b_prod   = 32'hFFFF_FFFF;
      b_pvalid = 1'b1;
      @(posedge clk); #1;
      if (i == 3) begin
        e = model(64'h3_FFFF_FFFC, BW);
        check("b_no_ovf_at_limit", 64'(b_ovf), 64'(e.ovf));
        check("b_result_at_limit", 64'(b_result), e.res);
      end
    end
    b_pvalid = 1'b0;
    e = model(64'(BT) * 64'hFFFF_FFFF, BW);
    check("b_done_valid", 64'(b_rvalid), 64'd1);
    check("b_ovf", 64'(b_ovf), 64'(e.ovf));
    check("b_result", 64'(b_result), e.res);
    b_rready = 1'b1;
    @(posedge clk); #1;
    b_rready = 1'b0;
    check("b_idle_ovf_kept", 64'({b_busy, b_ovf}), 64'd1);
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    check("b_restart_ovf_clear", 64'(b_ovf), 64'd0);

    repeat (3) @(posedge clk); #1;
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
